// File: rtl/mfp_window_feeder_if.sv
// Stream bundle between a sample producer, the window feeder and the
// MAC array input: sample channel in, packed tap window out, plus the
// advance enable that gates sample acceptance and flush stepping.
interface mfp_window_feeder_if #(
    parameter int DataW = 8,
    parameter int ArrL  = 7
);
    logic                    en;
    logic                    s_valid;
    logic                    s_ready;
    logic [DataW-1:0]        s_data;
    logic                    s_last;
    logic                    w_valid;
    logic                    w_ready;
    logic [DataW*ArrL-1:0]   w_arr;
    logic                    w_first;
    logic                    w_last;

    modport master (
        output en, s_valid, s_data, s_last, w_ready,
        input  s_ready, w_valid, w_arr, w_first, w_last
    );

    modport slave (
        input  en, s_valid, s_data, s_last, w_ready,
        output s_ready, w_valid, w_arr, w_first, w_last
    );
endinterface

// File: rtl/mfp_window_feeder.sv
// Tap-window generator for the symmetric FIR MAC array. Every accepted
// sample yields one ArrL-wide window centred on it, with line borders
// edge-replicated. The tap register drives w_arr directly, so the window
// is held for free whenever the consumer stalls.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for sample 0 of a line; it preloads every tap
// RUN      | shifting in samples; emits once H samples follow the centre
// FLUSH    | H self-timed steps replicating the newest sample
module mfp_window_feeder #(
    parameter int DataW = 8,
    parameter int ArrL  = 7
) (
    input  logic                 clk,
    input  logic                 aclr,
    mfp_window_feeder_if.slave   bus
);
    localparam int H  = ArrL / 2;
    localparam int KW = $clog2(H + 1);
    localparam logic [KW-1:0] K_MAX = KW'(H);
    localparam logic [KW-1:0] K_PRE = KW'(H - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    logic [1:0]                   state;
    logic [ArrL-1:0][DataW-1:0]   taps;
    logic [KW-1:0]                k;
    logic [KW-1:0]                fcnt;
    logic [KW-1:0]                k_inc;
    logic                         w_valid_q;
    logic                         w_first_q;
    logic                         w_last_q;
    logic                         free;
    logic                         accept;
    logic                         run_adv;
    logic                         flush_step;
    logic                         advance;
    logic                         emit;
    logic                         last_step;

    // Every advance needs the output slot free, which is what keeps
    // w_arr stable under backpressure. aclr gates ready so nothing is
    // taken while reset is held.
    assign free       = !w_valid_q || bus.w_ready;
    assign bus.s_ready = !aclr && bus.en && free && (state != ST_FLUSH);
    assign accept     = bus.s_valid && bus.s_ready;
    assign run_adv    = accept && (state == ST_RUN);
    assign flush_step = bus.en && free && (state == ST_FLUSH);
    assign advance    = run_adv || flush_step;

    // k counts samples seen to the right of the oldest centre; it
    // saturates at H, after which every advance emits.
    assign k_inc     = (k == K_MAX) ? K_MAX : k + 1'b1;
    assign emit      = advance && (k_inc == K_MAX);
    assign last_step = flush_step && (fcnt == K_PRE);

    assign bus.w_valid = w_valid_q;
    assign bus.w_first = w_first_q;
    assign bus.w_last  = w_last_q;
    assign bus.w_arr   = taps;

    // Line sequencing and the tap shift register.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            state <= ST_IDLE;
            taps  <= '0;
            k     <= '0;
            fcnt  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        taps  <= {ArrL{bus.s_data}};
                        k     <= '0;
                        fcnt  <= '0;
                        state <= bus.s_last ? ST_FLUSH : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        taps <= {bus.s_data, taps[ArrL-1:1]};
                        k    <= k_inc;
                        if (bus.s_last) begin
                            state <= ST_FLUSH;
                            fcnt  <= '0;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (flush_step) begin
                        taps <= {taps[ArrL-1], taps[ArrL-1:1]};
                        k    <= k_inc;
                        if (fcnt == K_PRE) begin
                            state <= ST_IDLE;
                        end else begin
                            fcnt <= fcnt + 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Output slot: load on emit, otherwise drain when the consumer takes it.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            w_valid_q <= 1'b0;
            w_first_q <= 1'b0;
            w_last_q  <= 1'b0;
        end else if (emit) begin
            w_valid_q <= 1'b1;
            w_first_q <= (k == K_PRE);
            w_last_q  <= last_step;
        end else if (bus.w_ready) begin
            w_valid_q <= 1'b0;
        end
    end
endmodule

// File: doc/mfp_window_feeder.md
# mfp_window_feeder

Streaming tap-window generator that feeds the symmetric fixed-point FIR MAC array used in the Gaussian-blur path. It accepts one sample per handshake and emits, per input sample, one ArrL-wide window centred on that sample, packed for direct connection to the MAC's In1Arr port. Line borders are edge-replicated: taps left of sample 0 repeat sample 0, and taps right of sample N-1 repeat sample N-1. It is the producer side of the MAC's array input.

## Interface
- DataW, 8, sample width in bits; opaque to this block, so signed and unsigned are both fine
- ArrL, 7, window length; odd and ≥3; H = ArrL/2 (integer)

- clk  in  1  clock, rising edge
- aclr  in  1  asynchronous active-high reset
- en  in  1  advance enable; 0 stalls input acceptance and flush stepping
- s_valid  in  1  input sample valid
- s_ready  out  1  input ready
- s_data  in  DataW  input sample
- s_last  in  1  marks the last sample of a line; qualified by s_valid
- w_valid  out  1  window valid
- w_ready  in  1  downstream ready
- w_arr  out  DataW*ArrL  window; tap j at [DataW*j +: DataW]; j=0 oldest (leftmost), j=H centre
- w_first  out  1  window is centred on sample 0 of its line
- w_last  out  1  window is centred on sample N-1 of its line

## Operation
- State: taps[0..ArrL-1], k (saturating 0..H), fcnt (0..H-1), w_valid/w_first/w_last registers, FSM {IDLE, RUN, FLUSH}.
- free = !w_valid || w_ready.
- Input accept: s_valid && s_ready, where s_ready = en && free && state!=FLUSH.
- IDLE, on accept (first sample of a line):
  - all taps ← s_data; k ← 0.
  - Next state is FLUSH with fcnt ← 0 if s_last, else RUN.
  - No window is emitted.
- RUN, on accept:
  - Shift: taps[j] ← taps[j+1], taps[ArrL-1] ← s_data.
  - k ← min(k+1, H).
  - Emit if the new k == H. w_first = 1 if the old k == H-1.
  - If s_last: go to FLUSH, fcnt ← 0.
- FLUSH step, when en && free:
  - Shift with taps[ArrL-1] ← taps[ArrL-1] (replicate newest).
  - k ← min(k+1, H).
  - Emit if the new k == H. w_first as in RUN.
  - On step fcnt == H-1: w_last ← 1 and go to IDLE; otherwise fcnt ← fcnt+1.
  - The final flush step always emits.
- Emit: w_valid ← 1, latching w_first/w_last. w_arr is the tap register itself.
- Taps change only on an advance, and every advance requires free, so w_arr is stable while w_valid && !w_ready.
- Non-emitting advance while free: w_valid ← 0 if w_ready was consumed.
- For a line of N samples, exactly N windows are emitted: N-H during RUN (when N>H) and min(N,H) during FLUSH.
- Window for centre c = samples clamp(c-H .. c+H, 0, N-1).
- w_first and w_last are both 1 on the single window of an N=1 line. For N≤H the first window appears during FLUSH.
- s_last is ignored unless accepted. There is no minimum line length.
- Back-to-back lines: the next line's first sample is accepted in IDLE the cycle after the final flush step.

## Timing
- Reset values (asynchronous, on aclr=1):
  - state=IDLE, taps=0, k=0, fcnt=0
  - w_valid=0, w_first=0, w_last=0
  - s_ready=0 while aclr is held
- Latency: a window whose trigger is sample c+H, accepted at edge t, is valid after edge t; one register stage.
- Throughput: one sample per cycle with w_ready=1.
- Flush overhead: H cycles per line (s_ready=0 during FLUSH).
- Stall behaviour:
  - w_valid && !w_ready forces s_ready=0 and freezes FLUSH.
  - w_valid, w_arr and the flags are held.
- en=0:
  - s_ready=0 and no flush step.
  - A pending window still transfers on w_ready (w_valid ← 0).
- aclr mid-line or mid-FLUSH: all partial state is discarded. The next accepted sample is treated as sample 0 of a new line.
- s_ready is combinational from en, w_valid, w_ready and state. It does not depend on s_valid.

## Test plan
- ArrL=5, w_ready=1, line 1..10, s_last on 10 -> 10 windows:
  - first {1,1,1,2,3} with w_first=1
  - second {1,1,2,3,4}
  - last {8,9,10,10,10} with w_last=1
  - s_ready low for exactly 2 cycles after 10
- ArrL=5, N=1, value 42 -> one window {42,42,42,42,42}, w_first=w_last=1, emitted on the second flush cycle.
- ArrL=5, N=2 (5,6) -> {5,5,5,6,6} (first), then {5,5,6,6,6} (last); both are emitted during FLUSH.
- ArrL=7, three back-to-back lines of 16 random samples, random w_ready (50%) and random en -> outputs match the clamp-window model with no loss or duplication; w_arr stable whenever w_valid && !w_ready.
- ArrL=7, aclr pulsed during FLUSH of line 1 -> w_valid=0 immediately; the next line 9,8,7,... produces a first window {9,9,9,9,8,7,6}.
- ArrL=3, s_valid held high with w_ready=0 -> one window emitted, then s_ready=0 and no further accepts until w_ready=1.
